// File: rtl/isolde_issue_pkg.sv
// Shared types for the ISOLDE issue sequencer: opcodes, op classes, error codes and FSM states.
package isolde_issue_pkg;

  typedef enum logic [3:0] {
    OPC_NOP          = 4'd0,
    OPC_VLE32_4      = 4'd1,
    OPC_GEMM         = 4'd2,
    OPC_CONV2D       = 4'd3,
    OPC_R_TYPE       = 4'd4,
    OPC_REDMULE      = 4'd5,
    OPC_REDMULE_GEMM = 4'd6
  } isolde_opcode_e;

  typedef enum logic [1:0] {
    OP_LOCAL0      = 2'd0,
    OP_LOCAL_TIMED = 2'd1,
    OP_OFFLOAD     = 2'd2
  } op_class_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_REJECT   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SPURIOUS = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCAL_WAIT = 2'd1,
    ISSUE      = 2'd2
  } seq_state_e;

  // Anything the sequencer does not recognise goes to the coprocessor.
  function automatic op_class_e classify_op(input isolde_opcode_e opc);
    case (opc)
      OPC_NOP, OPC_VLE32_4: return OP_LOCAL0;
      OPC_GEMM, OPC_CONV2D: return OP_LOCAL_TIMED;
      default:              return OP_OFFLOAD;
    endcase
  endfunction

endpackage

// File: rtl/isolde_id_scoreboard.sv
// Outstanding-ID scoreboard: one bit per in-flight offloaded op, lowest-free allocation,
// occupancy count and detection of results for IDs that are not in flight.
module isolde_id_scoreboard #(
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdW = $clog2(MaxOutstanding)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           set_i,
  input  logic [IdW-1:0] set_id_i,
  input  logic           clr_i,
  input  logic [IdW-1:0] clr_id_i,
  output logic [IdW-1:0] free_id_o,
  output logic           full_o,
  output logic [IdW:0]   count_o,
  output logic           clr_err_o
);

  logic [MaxOutstanding-1:0] valid_q;
  logic [IdW:0]              count_q;
  logic                      clr_eff;
  logic                      found;

  assign clr_eff   = clr_i && valid_q[clr_id_i];
  assign clr_err_o = clr_i && !valid_q[clr_id_i];
  assign full_o    = (count_q == (IdW+1)'(MaxOutstanding));
  assign count_o   = count_q;

  always_comb begin
    free_id_o = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < MaxOutstanding; i++) begin
      if (!valid_q[i] && !found) begin
        free_id_o = IdW'(i);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      if (clr_eff) valid_q[clr_id_i] <= 1'b0;
      if (set_i)   valid_q[set_id_i] <= 1'b1;
      case ({set_i, clr_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/isolde_issue_sequencer.sv
// ISOLDE execute-stage sequencer: classifies decoded ops, times local ops and issues
// offloaded ops over CV-X-IF with out-of-order completion tracking.
module isolde_issue_sequencer
  import isolde_issue_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NumRs          = 3,
  parameter int unsigned Imm32Ops       = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntW           = 8,
  parameter int unsigned TimeoutCycles  = 200,
  localparam int unsigned IdW = $clog2(MaxOutstanding)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dec_valid_i,
  output logic                    dec_ready_o,
  input  isolde_opcode_e          dec_opcode_i,
  input  logic [31:0]             dec_instr_i,
  input  logic [NumRs*XLEN-1:0]   dec_rs_i,
  input  logic [Imm32Ops*32-1:0]  dec_imm32_i,
  input  logic [Imm32Ops-1:0]     dec_imm32_valid_i,
  input  logic [CntW-1:0]         dec_local_lat_i,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  input  logic                    issue_accept_i,
  output logic [31:0]             issue_instr_o,
  output logic [NumRs*XLEN-1:0]   issue_rs_o,
  output logic [NumRs-1:0]        issue_rs_valid_o,
  output logic [Imm32Ops*32-1:0]  issue_imm32_o,
  output logic [Imm32Ops-1:0]     issue_imm32_valid_o,
  output logic [IdW-1:0]          issue_id_o,
  output logic                    commit_valid_o,
  output logic [IdW-1:0]          commit_id_o,
  output logic                    commit_kill_o,
  input  logic                    result_valid_i,
  input  logic [IdW-1:0]          result_id_i,
  output logic                    result_ready_o,
  output logic [IdW:0]            outstanding_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o
);

  seq_state_e            state_q, state_d;
  op_class_e             op_cls;
  logic                  dec_hs, issue_hs, tmo_fire, err_hit;
  err_code_e             err_new, err_code_q;
  logic                  err_q;
  logic [CntW-1:0]       lat_q, tmo_q;
  logic [31:0]           instr_q;
  logic [NumRs*XLEN-1:0] rs_q;
  logic [Imm32Ops*32-1:0] imm_q;
  logic [Imm32Ops-1:0]   immv_q;
  logic [IdW-1:0]        id_q, free_id, commit_id_q;
  logic                  commit_valid_q, commit_kill_q;
  logic                  sb_full, sb_clr_err;

  assign op_cls   = classify_op(dec_opcode_i);
  assign dec_hs   = dec_valid_i && dec_ready_o;
  assign issue_hs = (state_q == ISSUE) && issue_ready_i;
  assign tmo_fire = (state_q == ISSUE) && !issue_ready_i && (tmo_q == CntW'(TimeoutCycles - 1));

  isolde_id_scoreboard #(.MaxOutstanding(MaxOutstanding)) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (issue_hs && issue_accept_i),
    .set_id_i  (id_q),
    .clr_i     (result_valid_i),
    .clr_id_i  (result_id_i),
    .free_id_o (free_id),
    .full_o    (sb_full),
    .count_o   (outstanding_o),
    .clr_err_o (sb_clr_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dec_hs && op_cls == OP_LOCAL_TIMED) state_d = LOCAL_WAIT;
        else if (dec_hs && op_cls == OP_OFFLOAD) state_d = ISSUE;
      end
      LOCAL_WAIT: if (lat_q == CntW'(1)) state_d = IDLE;
      ISSUE:      if (issue_ready_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Same-cycle errors resolve by priority; only the very first one is recorded.
  always_comb begin
    err_hit = 1'b1;
    err_new = ERR_NONE;
    if (issue_hs && !issue_accept_i) err_new = ERR_REJECT;
    else if (tmo_fire)               err_new = ERR_TIMEOUT;
    else if (sb_clr_err)             err_new = ERR_SPURIOUS;
    else                             err_hit = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_q          <= '0;
      tmo_q          <= '0;
      instr_q        <= '0;
      rs_q           <= '0;
      imm_q          <= '0;
      immv_q         <= '0;
      id_q           <= '0;
      commit_valid_q <= 1'b0;
      commit_kill_q  <= 1'b0;
      commit_id_q    <= '0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      if (dec_hs && op_cls == OP_LOCAL_TIMED)
        lat_q <= (dec_local_lat_i == '0) ? CntW'(1) : dec_local_lat_i;
      else if (state_q == LOCAL_WAIT)
        lat_q <= lat_q - 1'b1;

      if (dec_hs && op_cls == OP_OFFLOAD) begin
        instr_q <= dec_instr_i;
        rs_q    <= dec_rs_i;
        imm_q   <= dec_imm32_i;
        immv_q  <= dec_imm32_valid_i;
        id_q    <= free_id;
        tmo_q   <= '0;
      end else if (state_q == ISSUE && !issue_ready_i && tmo_q != CntW'(TimeoutCycles)) begin
        tmo_q <= tmo_q + 1'b1;
      end

      commit_valid_q <= issue_hs;
      commit_kill_q  <= issue_hs && !issue_accept_i;
      if (issue_hs) commit_id_q <= id_q;

      if (err_hit && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_new;
      end
    end
  end

  assign dec_ready_o         = (state_q == IDLE) && !sb_full;
  assign issue_valid_o       = (state_q == ISSUE);
  assign issue_instr_o       = instr_q;
  assign issue_rs_o          = rs_q;
  assign issue_rs_valid_o    = {NumRs{issue_valid_o}};
  assign issue_imm32_o       = imm_q;
  assign issue_imm32_valid_o = immv_q;
  assign issue_id_o          = id_q;
  assign commit_valid_o      = commit_valid_q;
  assign commit_id_o         = commit_id_q;
  assign commit_kill_o       = commit_kill_q;
  assign result_ready_o      = 1'b1;
  assign busy_o              = (state_q != IDLE) || (outstanding_o != '0);
  assign err_o               = err_q;
  assign err_code_o          = err_code_q;

endmodule
